// File: rtl/seg7_scan_driver_if.sv
// Bundle between a hex-word source (debug/result registers) and the
// multiplexed 7-segment scan driver.
interface seg7_scan_driver_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] data;
  logic [NDIGITS-1:0]   dp_mask;
  logic                 load;
  logic                 blank_lz;
  logic [NDIGITS-1:0]   anode;
  logic [7:0]           catode;
  logic                 pending;
  logic                 frame_tick;

  modport master (
    output data, dp_mask, load, blank_lz,
    input  anode, catode, pending, frame_tick
  );

  modport slave (
    input  data, dp_mask, load, blank_lz,
    output anode, catode, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: tear-free display copy,
// programmable per-digit dwell, decimal points and leading-zero blanking.
module seg7_scan_driver #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int DW = 4 * NDIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [DW-1:0]      shadow_data;
  logic [NDIGITS-1:0] shadow_dp;
  logic [DW-1:0]      disp_data;
  logic [NDIGITS-1:0] disp_dp;
  logic [PW-1:0]      prescaler;
  logic [IW-1:0]      idx;
  logic               pending_q;
  logic               wrap_q;

  logic               tc;
  logic               wrap;

  assign tc   = (prescaler == PRE_LAST);
  assign wrap = tc && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      if (tc) begin
        prescaler <= '0;
        idx       <= wrap ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Display only moves at the frame wrap so no frame mixes old and new
  // digits; a load landing on the wrap itself bypasses the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_data <= bus.data;
        shadow_dp   <= bus.dp_mask;
      end
      if (wrap) begin
        pending_q <= 1'b0;
        if (bus.load) begin
          disp_data <= bus.data;
          disp_dp   <= bus.dp_mask;
        end else if (pending_q) begin
          disp_data <= shadow_data;
          disp_dp   <= shadow_dp;
        end
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  logic [NDIGITS-1:0] zero_from;
  logic               run_zero;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_blank;
  logic [7:0]         cur_seg;
  logic [7:0]         cur_cat;
  logic [NDIGITS-1:0] cur_anode;

  // zero_from[i]: every displayed nibble from digit i upward is zero.
  always_comb begin
    zero_from = '0;
    run_zero  = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (disp_data[4*i +: 4] == 4'h0);
      zero_from[i] = run_zero;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = disp_data[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = bus.blank_lz && (i != 0) && zero_from[i] && !disp_dp[i];
      end
    end
  end

  always_comb begin
    cur_seg = 8'hFF;
    case (cur_nib)
      4'h0: cur_seg = 8'h03;
      4'h1: cur_seg = 8'h9F;
      4'h2: cur_seg = 8'h25;
      4'h3: cur_seg = 8'h0D;
      4'h4: cur_seg = 8'h99;
      4'h5: cur_seg = 8'h49;
      4'h6: cur_seg = 8'h41;
      4'h7: cur_seg = 8'h1F;
      4'h8: cur_seg = 8'h01;
      4'h9: cur_seg = 8'h09;
      4'hA: cur_seg = 8'h11;
      4'hB: cur_seg = 8'hC1;
      4'hC: cur_seg = 8'h63;
      4'hD: cur_seg = 8'h85;
      4'hE: cur_seg = 8'h61;
      4'hF: cur_seg = 8'h71;
      default: cur_seg = 8'hFF;
    endcase
  end

  always_comb begin
    cur_cat   = cur_blank ? 8'hFF : {cur_seg[7:1], ~cur_dp};
    cur_anode = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      cur_anode[i] = !((idx == IW'(i)) && !cur_blank);
    end
  end

  // frame_tick is delayed one extra cycle so it lines up with the first
  // registered output cycle of digit 0 rather than with the wrap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.anode      <= '1;
      bus.catode     <= 8'hFF;
      bus.frame_tick <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      bus.anode      <= cur_anode;
      bus.catode     <= cur_cat;
      wrap_q         <= wrap;
      bus.frame_tick <= wrap_q;
    end
  end

  assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NDIGITS=4, REFRESH_DIV=4:
// each runFrame call covers one 16-cycle frame with hand-derived expectations.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  seg7_scan_driver_if #(.NDIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NDIGITS    (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic l);
    bus.data    = d;
    bus.dp_mask = m;
    bus.load    = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  // One frame starting right after a wrap (or release): the display shows
  // word/dp throughout; loads at cycles ldA/ldB (0 = none) only raise pending.
  task automatic runFrame(input string name, input logic [15:0] word, input logic [3:0] dp,
                          input logic blz, input logic tick0,
                          input int ldA, input logic [15:0] dA, input logic [3:0] mA,
                          input int ldB, input logic [15:0] dB, input logic [3:0] mB);
    int         d;
    logic       blankDig;
    logic [3:0] nib;
    logic [3:0] eAn;
    logic [7:0] eCat;
    logic       ePend;
    logic       eTick;
    bus.blank_lz = blz;
    for (int c = 1; c <= 16; c++) begin
      if (c == ldA) applyStimulus(dA, mA, 1'b1);
      else if (c == ldB) applyStimulus(dB, mB, 1'b1);
      else applyStimulus(16'h0, 4'h0, 1'b0);
      tick();
      d        = (c - 1) / RD;
      nib      = word[4*d +: 4];
      blankDig = blz && (d > 0) && ((word >> (4*d)) == 16'h0) && !dp[d];
      eAn      = blankDig ? 4'hF : ~(4'b0001 << d);
      eCat     = blankDig ? 8'hFF : (dp[d] ? (segOf(nib) & 8'hFE) : segOf(nib));
      ePend    = (ldA != 0 && c >= ldA && c < 16) || (ldB != 0 && c >= ldB && c < 16);
      eTick    = (c == 1) ? tick0 : 1'b0;
      checkOutput($sformatf("%s c%0d anode", name, c), {28'h0, bus.anode}, {28'h0, eAn});
      checkOutput($sformatf("%s c%0d catode", name, c), {24'h0, bus.catode}, {24'h0, eCat});
      checkOutput($sformatf("%s c%0d pending", name, c), {31'h0, bus.pending}, {31'h0, ePend});
      checkOutput($sformatf("%s c%0d frame_tick", name, c), {31'h0, bus.frame_tick}, {31'h0, eTick});
    end
    applyStimulus(16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.blank_lz = 1'b0;
    applyStimulus(16'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset%0d anode", i), {28'h0, bus.anode}, 32'hF);
      checkOutput($sformatf("reset%0d catode", i), {24'h0, bus.catode}, 32'hFF);
      checkOutput($sformatf("reset%0d pending", i), {31'h0, bus.pending}, 32'h0);
    end
    reset = 1'b0;
    checkOutput("release anode", {28'h0, bus.anode}, 32'hF);
    checkOutput("release catode", {24'h0, bus.catode}, 32'hFF);

    runFrame("frameA", 16'h0000, 4'h0, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("frameB", 16'h0000, 4'h0, 1'b0, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // Load lands while digit 2 is lit; old digits must persist to the wrap.
    runFrame("tearC", 16'h0000, 4'h0, 1'b0, 1'b1, 10, 16'h12AF, 4'h0, 0, 16'h0, 4'h0);
    // Load coincident with the wrap edge goes straight to the display.
    runFrame("tearD", 16'h12AF, 4'h0, 1'b0, 1'b1, 16, 16'h0008, 4'h0, 0, 16'h0, 4'h0);
    runFrame("wrapE", 16'h0008, 4'h0, 1'b0, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("blankF", 16'h0008, 4'h0, 1'b1, 1'b1, 2, 16'h0030, 4'h0, 0, 16'h0, 4'h0);
    runFrame("blankG", 16'h0030, 4'h0, 1'b1, 1'b1, 5, 16'h0030, 4'h8, 0, 16'h0, 4'h0);
    runFrame("blankH", 16'h0030, 4'h8, 1'b1, 1'b1, 3, 16'h1111, 4'h0, 7, 16'h2222, 4'h0);
    runFrame("lastI", 16'h2222, 4'h0, 1'b1, 1'b1, 8, 16'h4567, 4'h0, 0, 16'h0, 4'h0);
    runFrame("hexJ", 16'h4567, 4'h0, 1'b0, 1'b1, 12, 16'h9BCD, 4'h5, 0, 16'h0, 4'h0);
    runFrame("hexK", 16'h9BCD, 4'h5, 1'b0, 1'b1, 4, 16'hE000, 4'h0, 0, 16'h0, 4'h0);
    runFrame("hexL", 16'hE000, 4'h0, 1'b1, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    // Reset while digit 1 is lit and a load is pending.
    bus.blank_lz = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) applyStimulus(16'h5555, 4'h0, 1'b1);
      else applyStimulus(16'h0, 4'h0, 1'b0);
      tick();
      checkOutput($sformatf("midrst c%0d anode", c), {28'h0, bus.anode},
                  (c <= 4) ? 32'hE : 32'hD);
      checkOutput($sformatf("midrst c%0d catode", c), {24'h0, bus.catode}, 32'h03);
    end
    checkOutput("midrst pending before", {31'h0, bus.pending}, 32'h1);
    reset = 1'b1;
    applyStimulus(16'h9999, 4'hF, 1'b1);
    tick();
    checkOutput("midrst anode", {28'h0, bus.anode}, 32'hF);
    checkOutput("midrst catode", {24'h0, bus.catode}, 32'hFF);
    checkOutput("midrst pending", {31'h0, bus.pending}, 32'h0);
    checkOutput("midrst frame_tick", {31'h0, bus.frame_tick}, 32'h0);
    applyStimulus(16'h0, 4'h0, 1'b0);
    tick();
    checkOutput("midrst2 anode", {28'h0, bus.anode}, 32'hF);
    reset = 1'b0;
    runFrame("postM", 16'h0000, 4'h0, 1'b0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("postN", 16'h0000, 4'h0, 1'b0, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
